clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_chan.sv | 97 +++++++++
 rtl/clk_div_multi.sv | 53 +++++
 tb/tb_clk_div_multi.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared constants for the multi-channel clock divider.
//   W_DEF       : default divisor / counter width
//   DIV_RST_DEF : default divisor loaded into every channel at reset
//   NCH_MAX     : largest supported number of channels
// ---------------------------------------------------------------------------
package clk_div_pkg;

    localparam int W_DEF       = 27;
    localparam int DIV_RST_DEF = 100000000;
    localparam int NCH_MAX     = 8;

endpackage : clk_div_pkg

// File: rtl/clk_div_chan.sv
// ---------------------------------------------------------------------------
// clk_div_chan
// One divider channel.  Counts enabled cycles up to the effective divisor,
// toggles clkout and pulses tick at each terminal count.  A divisor loaded
// mid half-period is parked in a shadow register and applied at the next
// terminal count, so a half-period is never cut short.
//
// Ports
//   clk    in   system clock, all state changes on posedge
//   rst    in   asynchronous active-low reset
//   en     in   count enable
//   sync   in   phase restart (cnt, clkout, tick forced to 0)
//   ld     in   one-cycle divisor load strobe
//   div_i  in   divisor value sampled when ld=1
//   clkout out  divided clock (registered data signal)
//   tick   out  one-cycle pulse coincident with each clkout toggle
//   pend   out  a shadow divisor is waiting to be applied
// ---------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sync,
    input  logic         ld,
    input  logic [W-1:0] div_i,
    output logic         clkout,
    output logic         tick,
    output logic         pend
);

    localparam logic [W-1:0] DIV_RST_W = W'(DIV_RST);
    localparam logic [W-1:0] ONE       = W'(1);

    logic [W-1:0] cnt;   // enabled cycles since last terminal count
    logic [W-1:0] d;     // active divisor
    logic [W-1:0] s;     // shadow divisor
    logic [W-1:0] deff;  // divisor actually used (0 behaves as 1)
    logic         term;  // terminal count this cycle
    logic         apply_now;

    assign deff = (d == '0) ? ONE : d;

    // ">=" rather than "==": a smaller divisor applied while the channel is
    // stopped must not let cnt run past the new terminal value and wrap.
    assign term = en && !sync && (cnt >= (deff - ONE));

    // A stopped channel or a channel at its terminal count has no
    // half-period in progress, so a new divisor can take effect directly.
    assign apply_now = term || !en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            d      <= DIV_RST_W;
            s      <= DIV_RST_W;
            clkout <= 1'b0;
            tick   <= 1'b0;
            pend   <= 1'b0;
        end else begin
            // Divisor handling: a fresh ld always wins over a pending shadow.
            if (ld) begin
                s <= div_i;
                if (apply_now) begin
                    d    <= div_i;
                    pend <= 1'b0;
                end else begin
                    pend <= 1'b1;
                end
            end else if (pend && (apply_now || sync)) begin
                d    <= s;
                pend <= 1'b0;
            end

            // Counter and outputs.
            if (sync) begin
                cnt    <= '0;
                clkout <= 1'b0;
                tick   <= 1'b0;
            end else if (!en) begin
                tick <= 1'b0;
            end else if (term) begin
                cnt    <= '0;
                clkout <= ~clkout;
                tick   <= 1'b1;
            end else begin
                cnt  <= cnt + ONE;
                tick <= 1'b0;
            end
        end
    end

endmodule : clk_div_chan

// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
// NCH independent clock-divider channels sharing clk, rst, sync and div_i.
// clkout is a plain registered data output; nothing inside this block is
// clocked by it.
//
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   en     in   [NCH] per-channel count enable
//   sync   in   global phase restart for all channels
//   ld     in   [NCH] per-channel divisor load strobe
//   div_i  in   [W]   shared divisor bus
//   clkout out  [NCH] divided clocks
//   tick   out  [NCH] one-cycle pulse at each clkout toggle
//   pend   out  [NCH] loaded divisor waiting for the next terminal count
// ---------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int W       = W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic [NCH-1:0] ld,
    input  logic [W-1:0]   div_i,
    output logic [NCH-1:0] clkout,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pend
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        clk_div_chan #(
            .W       (W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en     (en[c]),
            .sync   (sync),
            .ld     (ld[c]),
            .div_i  (div_i),
            .clkout (clkout[c]),
            .tick   (tick[c]),
            .pend   (pend[c])
        );
    end

endmodule : clk_div_multi

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
// Self-checking bench for clk_div_multi (NCH=2, W=8, DIV_RST=4).
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge against a per-channel reference model and hand-derived
// expectations.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int NCH     = 2;
    localparam int W       = 8;
    localparam int DIV_RST = 4;
    localparam int OW      = 3 * NCH;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] en  = '0;
    logic           sync = 1'b0;
    logic [NCH-1:0] ld  = '0;
    logic [W-1:0]   div_i = '0;
    logic [NCH-1:0] clkout, tick, pend;

    always #5 clk = ~clk;

    clk_div_multi #(.NCH(NCH), .W(W), .DIV_RST(DIV_RST)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .ld     (ld),
        .div_i  (div_i),
        .clkout (clkout),
        .tick   (tick),
        .pend   (pend)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [OW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is described by how many enabled cycles it has counted
    // in the current half-period, the divisor in force, and a parked divisor.
    int m_cnt [NCH];
    int m_d   [NCH];
    int m_s   [NCH];
    bit m_pend[NCH];
    bit m_clk [NCH];
    bit m_tick[NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_d[c] = DIV_RST; m_s[c] = DIV_RST;
            m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_edge(input logic [NCH-1:0] e, input logic s,
                              input logic [NCH-1:0] l, input logic [W-1:0] dv);
        logic [OW-1:0] o;
        for (int c = 0; c < NCH; c++) begin
            int half_len;
            bit ends_half, idle;
            half_len  = (m_d[c] == 0) ? 1 : m_d[c];
            ends_half = e[c] && !s && (m_cnt[c] + 1 >= half_len);
            idle      = ends_half || !e[c];
            if (l[c]) begin
                m_s[c] = int'(dv);
                if (idle) begin m_d[c] = int'(dv); m_pend[c] = 0; end
                else m_pend[c] = 1;
            end else if (m_pend[c] && (idle || s)) begin
                m_d[c] = m_s[c]; m_pend[c] = 0;
            end
            if (s) begin
                m_cnt[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
            end else if (!e[c]) begin
                m_tick[c] = 0;
            end else if (ends_half) begin
                m_cnt[c] = 0; m_clk[c] = !m_clk[c]; m_tick[c] = 1;
            end else begin
                m_cnt[c] = (m_cnt[c] + 1) % (1 << W); m_tick[c] = 0;
            end
            o[c]         = m_clk[c];
            o[NCH + c]   = m_tick[c];
            o[2*NCH + c] = m_pend[c];
        end
        exp_q.push_back(o);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic [NCH-1:0] e, input logic s,
                       input logic [NCH-1:0] l, input logic [W-1:0] dv);
        logic [OW-1:0] o;
        en = e; sync = s; ld = l; div_i = dv;
        @(posedge clk);
        model_edge(e, s, l, dv);
        #1;
        o = exp_q.pop_front();
        chk("model_clkout", 32'(clkout), 32'(o[NCH-1:0]));
        chk("model_tick",   32'(tick),   32'(o[2*NCH-1:NCH]));
        chk("model_pend",   32'(pend),   32'(o[3*NCH-1:2*NCH]));
        @(negedge clk);
        ld = '0; sync = 1'b0;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] exp_clk;
        logic [NCH-1:0] exp_tick;
        logic [NCH-1:0] exp_pend;
    } vec_t;

    vec_t tbl[12];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic hold_val;

        // Divider after reset release with DIV_RST=4: toggle every 4 cycles.
        tbl[0]  = '{2'b11, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{2'b11, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{2'b11, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{2'b11, 2'b11, 2'b11, 2'b00};
        tbl[4]  = '{2'b11, 2'b11, 2'b00, 2'b00};
        tbl[5]  = '{2'b11, 2'b11, 2'b00, 2'b00};
        tbl[6]  = '{2'b11, 2'b11, 2'b00, 2'b00};
        tbl[7]  = '{2'b11, 2'b00, 2'b11, 2'b00};
        tbl[8]  = '{2'b11, 2'b00, 2'b00, 2'b00};
        tbl[9]  = '{2'b11, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{2'b11, 2'b00, 2'b00, 2'b00};
        tbl[11] = '{2'b11, 2'b11, 2'b11, 2'b00};

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_clkout", 32'(clkout), 32'(0));
        chk("reset_tick",   32'(tick),   32'(0));
        chk("reset_pend",   32'(pend),   32'(0));
        rst = 1'b1;

        // ---- table: reset divisor ----
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].en, 1'b0, '0, '0);
            chk("tbl_clkout", 32'(clkout), 32'(tbl[i].exp_clk));
            chk("tbl_tick",   32'(tick),   32'(tbl[i].exp_tick));
            chk("tbl_pend",   32'(pend),   32'(tbl[i].exp_pend));
        end

        // ---- mid-period load: ch0 D=5, ld div=2 at cnt=1 ----
        cyc(2'b00, 1'b0, 2'b01, 8'd5);
        cyc(2'b00, 1'b1, 2'b00, 8'd0);
        cyc(2'b11, 1'b0, 2'b00, 8'd0);            // cnt -> 1
        cyc(2'b11, 1'b0, 2'b01, 8'd2);            // load during cnt=1
        chk("midld_pend_set", 32'(pend[0]), 32'(1));
        cyc(2'b11, 1'b0, 2'b00, 8'd0);
        cyc(2'b11, 1'b0, 2'b00, 8'd0);
        chk("midld_e4_clk", 32'(clkout[0]), 32'(0));
        cyc(2'b11, 1'b0, 2'b00, 8'd0);            // 5th cycle: full half-period
        chk("midld_e5_clk",  32'(clkout[0]), 32'(1));
        chk("midld_e5_tick", 32'(tick[0]),   32'(1));
        chk("midld_e5_pend", 32'(pend[0]),   32'(0));
        cyc(2'b11, 1'b0, 2'b00, 8'd0);
        chk("midld_e6_clk", 32'(clkout[0]), 32'(1));
        cyc(2'b11, 1'b0, 2'b00, 8'd0);
        chk("midld_e7_clk",  32'(clkout[0]), 32'(0));
        chk("midld_e7_tick", 32'(tick[0]),   32'(1));
        cyc(2'b11, 1'b0, 2'b00, 8'd0);
        cyc(2'b11, 1'b0, 2'b00, 8'd0);
        chk("midld_e9_clk", 32'(clkout[0]), 32'(1));

        // ---- zero divisor on ch0 ----
        cyc(2'b00, 1'b0, 2'b01, 8'd0);
        chk("zero_pend", 32'(pend[0]), 32'(0));
        cyc(2'b00, 1'b1, 2'b00, 8'd0);
        for (int k = 1; k <= 4; k++) begin
            cyc(2'b01, 1'b0, 2'b00, 8'd0);
            chk("zero_tick",   32'(tick[0]),   32'(1));
            chk("zero_clkout", 32'(clkout[0]), 32'(k % 2));
            chk("zero_tick1",  32'(tick[1]),   32'(0));
        end

        // ---- sync with different divisors ----
        cyc(2'b00, 1'b0, 2'b11, 8'd3);
        cyc(2'b00, 1'b0, 2'b10, 8'd6);
        repeat (7) cyc(2'b11, 1'b0, 2'b00, 8'd0);
        cyc(2'b11, 1'b1, 2'b00, 8'd0);
        chk("sync_clkout", 32'(clkout), 32'(0));
        chk("sync_tick",   32'(tick),   32'(0));
        for (int k = 1; k <= 6; k++) begin
            cyc(2'b11, 1'b0, 2'b00, 8'd0);
            if (k == 3) begin
                chk("sync_e3_clk",  32'(clkout), 32'(2'b01));
                chk("sync_e3_tick", 32'(tick),   32'(2'b01));
            end
            if (k == 6) begin
                chk("sync_e6_clk",  32'(clkout), 32'(2'b10));
                chk("sync_e6_tick", 32'(tick),   32'(2'b11));
            end
        end

        // ---- enable hold on ch1 ----
        repeat (2) cyc(2'b11, 1'b0, 2'b00, 8'd0);
        hold_val = m_clk[1];
        repeat (10) begin
            cyc(2'b01, 1'b0, 2'b00, 8'd0);
            chk("hold_clk1",  32'(clkout[1]), 32'(hold_val));
            chk("hold_tick1", 32'(tick[1]),   32'(0));
        end
        repeat (8) cyc(2'b11, 1'b0, 2'b00, 8'd0);

        // ---- randomized traffic ----
        for (int i = 0; i < 400; i++) begin
            logic [NCH-1:0] r_en, r_ld;
            logic           r_sync;
            logic [W-1:0]   r_div;
            r_en   = NCH'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) r_en = '1;
            r_sync = ($urandom_range(0, 39) == 0);
            r_ld   = ($urandom_range(0, 7) == 0) ? NCH'($urandom_range(1, 3)) : '0;
            r_div  = W'($urandom_range(0, 7));
            cyc(r_en, r_sync, r_ld, r_div);
        end

        // ---- asynchronous reset between edges ----
        cyc(2'b11, 1'b0, 2'b00, 8'd0);
        cyc(2'b11, 1'b0, 2'b11, 8'd9);
        #2 rst = 1'b0;
        #1;
        chk("arst_clkout", 32'(clkout), 32'(0));
        chk("arst_tick",   32'(tick),   32'(0));
        chk("arst_pend",   32'(pend),   32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(2'b11, 1'b0, 2'b00, 8'd0);
            if (k == 4) chk("arst_first_tick", 32'(tick), 32'(2'b11));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_clk_div_multi
